// File: rtl/bp_uce_mb.sv
// Unicore cache engine with multi-beat fills: services L1 misses (with optional
// dirty writeback), uncached loads and posted uncached stores, tracking posted-write credits.
module bp_uce_mb #(
    parameter int paddr_width_p = 40,
    parameter int block_width_p = 512,
    parameter int fill_width_p  = 128,
    parameter int assoc_p       = 8,
    parameter int credits_p     = 4,
    localparam int beats_lp     = block_width_p / fill_width_p,
    localparam int beat_w_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1,
    localparam int way_w_lp     = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int cred_w_lp    = $clog2(credits_p + 1),
    localparam int blk_off_lp   = $clog2(block_width_p / 8)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_type_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [way_w_lp-1:0]      req_way_i,
    input  logic                     req_dirty_i,
    input  logic [paddr_width_p-1:0] req_victim_addr_i,
    input  logic [63:0]              req_data_i,
    input  logic [1:0]               req_size_i,
    output logic                     data_rd_v_o,
    output logic [way_w_lp-1:0]      data_rd_way_o,
    input  logic                     data_rd_v_i,
    input  logic [block_width_p-1:0] data_rd_data_i,
    output logic                     fill_v_o,
    input  logic                     fill_yumi_i,
    output logic                     fill_uc_o,
    output logic                     fill_last_o,
    output logic [beat_w_lp-1:0]     fill_beat_o,
    output logic [way_w_lp-1:0]      fill_way_o,
    output logic [paddr_width_p-1:0] fill_addr_o,
    output logic [fill_width_p-1:0]  fill_data_o,
    output logic                     mem_cmd_v_o,
    input  logic                     mem_cmd_ready_i,
    output logic [1:0]               mem_cmd_type_o,
    output logic [paddr_width_p-1:0] mem_cmd_addr_o,
    output logic [2:0]               mem_cmd_size_o,
    output logic [block_width_p-1:0] mem_cmd_data_o,
    input  logic                     mem_resp_v_i,
    output logic                     mem_resp_yumi_o,
    input  logic [1:0]               mem_resp_type_i,
    input  logic [block_width_p-1:0] mem_resp_data_i,
    output logic                     credits_full_o,
    output logic                     credits_empty_o
);

    typedef enum logic [2:0] {
        e_ready, e_wb_read, e_wb_send, e_rd_send,
        e_rd_wait, e_fill, e_uc_wait, e_uc_fill
    } state_e;

    localparam logic [1:0] req_uc_load_lp  = 2'd2;
    localparam logic [1:0] req_uc_store_lp = 2'd3;
    localparam logic [1:0] cmd_rd_lp       = 2'd0;
    localparam logic [1:0] cmd_wr_lp       = 2'd1;
    localparam logic [1:0] cmd_uc_rd_lp    = 2'd2;
    localparam logic [1:0] cmd_uc_wr_lp    = 2'd3;

    state_e                     state_r, state_n;
    logic [1:0]                 type_r;
    logic [paddr_width_p-1:0]   addr_r;
    logic [paddr_width_p-1:0]   victim_r;
    logic [way_w_lp-1:0]        way_r;
    logic [63:0]                uc_data_r;
    logic [1:0]                 size_r;
    logic [block_width_p-1:0]   data_r;
    logic [beat_w_lp-1:0]       beat_r;
    logic [cred_w_lp-1:0]       cred_r;
    logic                       wb_rd_sent_r;

    logic                       req_accept;
    logic                       cmd_hs;
    logic                       resp_rd_ok;
    logic                       cred_inc;
    logic                       cred_dec;
    logic [paddr_width_p-1:0]   block_addr;

    // Write responses drain at any time; read data is only taken while a read is pending.
    assign req_accept      = req_v_i & req_ready_o;
    assign cmd_hs          = mem_cmd_v_o & mem_cmd_ready_i;
    assign resp_rd_ok      = mem_resp_v_i & ~mem_resp_type_i[0]
                           & ((state_r == e_rd_wait) | (state_r == e_uc_wait));
    assign mem_resp_yumi_o = ~reset_i & ((mem_resp_v_i & mem_resp_type_i[0]) | resp_rd_ok);
    assign cred_inc        = cmd_hs & mem_cmd_type_o[0];
    assign cred_dec        = mem_resp_yumi_o & mem_resp_type_i[0];
    assign block_addr      = {addr_r[paddr_width_p-1:blk_off_lp], {blk_off_lp{1'b0}}};
    assign credits_full_o  = (cred_r == cred_w_lp'(credits_p));
    assign credits_empty_o = (cred_r == '0);
    assign data_rd_way_o   = way_r;
    assign fill_way_o      = way_r;
    assign fill_beat_o     = beat_r;

    always_comb begin
        state_n        = state_r;
        req_ready_o    = 1'b0;
        data_rd_v_o    = 1'b0;
        fill_v_o       = 1'b0;
        fill_uc_o      = 1'b0;
        fill_last_o    = 1'b0;
        fill_addr_o    = block_addr;
        fill_data_o    = data_r[beat_r*fill_width_p +: fill_width_p];
        mem_cmd_v_o    = 1'b0;
        mem_cmd_type_o = cmd_rd_lp;
        mem_cmd_addr_o = block_addr;
        mem_cmd_size_o = 3'(blk_off_lp);
        mem_cmd_data_o = data_r;

        case (state_r)
            e_ready: begin
                req_ready_o = ~credits_full_o;
                if (req_accept) begin
                    if (!req_type_i[1] && req_dirty_i)
                        state_n = e_wb_read;
                    else
                        state_n = e_rd_send;
                end
            end
            e_wb_read: begin
                data_rd_v_o = ~wb_rd_sent_r;
                if (data_rd_v_i)
                    state_n = e_wb_send;
            end
            e_wb_send: begin
                mem_cmd_v_o    = 1'b1;
                mem_cmd_type_o = cmd_wr_lp;
                mem_cmd_addr_o = victim_r;
                if (cmd_hs)
                    state_n = e_rd_send;
            end
            e_rd_send: begin
                mem_cmd_v_o = 1'b1;
                if (type_r == req_uc_load_lp) begin
                    mem_cmd_type_o = cmd_uc_rd_lp;
                    mem_cmd_addr_o = addr_r;
                    mem_cmd_size_o = {1'b0, size_r};
                end else if (type_r == req_uc_store_lp) begin
                    mem_cmd_type_o = cmd_uc_wr_lp;
                    mem_cmd_addr_o = addr_r;
                    mem_cmd_size_o = {1'b0, size_r};
                    mem_cmd_data_o = block_width_p'(uc_data_r);
                end
                if (cmd_hs) begin
                    if (type_r == req_uc_store_lp)
                        state_n = e_ready;
                    else if (type_r == req_uc_load_lp)
                        state_n = e_uc_wait;
                    else
                        state_n = e_rd_wait;
                end
            end
            e_rd_wait: begin
                if (resp_rd_ok)
                    state_n = e_fill;
            end
            e_uc_wait: begin
                if (resp_rd_ok)
                    state_n = e_uc_fill;
            end
            e_fill: begin
                fill_v_o    = 1'b1;
                fill_last_o = (beat_r == beat_w_lp'(beats_lp - 1));
                if (fill_yumi_i && fill_last_o)
                    state_n = e_ready;
            end
            e_uc_fill: begin
                fill_v_o    = 1'b1;
                fill_uc_o   = 1'b1;
                fill_last_o = 1'b1;
                fill_addr_o = addr_r;
                fill_data_o = data_r[fill_width_p-1:0];
                if (fill_yumi_i)
                    state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    // A single data register holds the victim block, then the fill/uc read data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= e_ready;
            type_r       <= '0;
            addr_r       <= '0;
            victim_r     <= '0;
            way_r        <= '0;
            uc_data_r    <= '0;
            size_r       <= '0;
            data_r       <= '0;
            beat_r       <= '0;
            cred_r       <= '0;
            wb_rd_sent_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            wb_rd_sent_r <= (state_r == e_wb_read);
            if (req_accept) begin
                type_r    <= req_type_i;
                addr_r    <= req_addr_i;
                victim_r  <= req_victim_addr_i;
                way_r     <= req_way_i;
                uc_data_r <= req_data_i;
                size_r    <= req_size_i;
            end
            if (state_r == e_wb_read && data_rd_v_i)
                data_r <= data_rd_data_i;
            if (resp_rd_ok)
                data_r <= mem_resp_data_i;
            if (state_r == e_fill && fill_yumi_i)
                beat_r <= fill_last_o ? '0 : beat_r + 1'b1;
            if (cred_inc && !cred_dec)
                cred_r <= cred_r + 1'b1;
            else if (cred_dec && !cred_inc)
                cred_r <= cred_r - 1'b1;
        end
    end

    // Credit underflow/overflow means the network or cache broke the protocol.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(cred_dec && !cred_inc && credits_empty_o));
            assert (!(cred_inc && !cred_dec && credits_full_o));
        end
    end

endmodule
